// File: rtl/bp_stream_axil_bridge_pkg.sv
// Shared types for the AXI-Lite to bp_stream bridge: response codes and FSM state encodings.
package bp_stream_axil_bridge_pkg;

  typedef enum logic [1:0] {
    e_axi_resp_okay   = 2'b00,
    e_axi_resp_slverr = 2'b10
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_STREAM  = 2'd1,
    W_RESP    = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/bp_stream_axil_bridge_fifo.sv
// Small 1-read/1-write FIFO buffering the return stream; head is visible combinationally.
module bp_stream_axil_bridge_fifo
  import bp_stream_axil_bridge_pkg::*;
#(
  parameter int unsigned width_p = 32,
  parameter int unsigned els_p   = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned PTR_W = $clog2(els_p);

  logic [PTR_W:0]       r_wptr;
  logic [PTR_W:0]       r_rptr;
  logic [width_p-1:0]   r_mem [els_p];
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign ready_o = !w_full;
  assign v_o     = !w_empty;
  assign data_o  = r_mem[r_rptr[PTR_W-1:0]];
  assign w_push  = v_i && !w_full;
  assign w_pop   = yumi_i && !w_empty;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < int'(els_p); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr[PTR_W-1:0]] <= data_i;
        r_wptr                   <= r_wptr + (PTR_W+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bp_stream_axil_bridge.sv
// AXI-Lite slave: host writes become valid/yumi stream beats; host reads drain the return FIFO.
module bp_stream_axil_bridge
  import bp_stream_axil_bridge_pkg::*;
#(
  parameter int unsigned axil_addr_width_p = 32,
  parameter int unsigned axil_data_width_p = 32,
  parameter int unsigned rx_fifo_els_p     = 16,
  parameter logic [31:0] nbf_addr_p        = 32'h10,
  parameter logic [31:0] mmio_addr_p       = 32'h20,
  parameter logic [31:0] rx_data_addr_p    = 32'h30,
  parameter logic [31:0] rx_count_addr_p   = 32'h34
) (
  input  logic                           clk_i,
  input  logic                           reset_i,

  input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,
  input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
  input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,
  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,

  input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
  input  logic                           s_axil_arvalid_i,
  output logic                           s_axil_arready_o,
  output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
  output logic [1:0]                     s_axil_rresp_o,
  output logic                           s_axil_rvalid_o,
  input  logic                           s_axil_rready_i,

  output logic                           stream_v_o,
  output logic [axil_addr_width_p-1:0]   stream_addr_o,
  output logic [axil_data_width_p-1:0]   stream_data_o,
  input  logic                           stream_yumi_i,

  input  logic                           stream_v_i,
  input  logic [axil_data_width_p-1:0]   stream_data_i,
  output logic                           stream_ready_o
);

  localparam int unsigned CNT_W = $clog2(rx_fifo_els_p + 1);

  localparam logic [axil_addr_width_p-1:0] NBF_ADDR   = axil_addr_width_p'(nbf_addr_p);
  localparam logic [axil_addr_width_p-1:0] MMIO_ADDR  = axil_addr_width_p'(mmio_addr_p);
  localparam logic [axil_addr_width_p-1:0] RXD_ADDR   = axil_addr_width_p'(rx_data_addr_p);
  localparam logic [axil_addr_width_p-1:0] RXC_ADDR   = axil_addr_width_p'(rx_count_addr_p);

  // ---------------- write path ----------------
  wr_state_e                      r_wr_state;
  wr_state_e                      w_wr_state_nxt;
  logic                           r_aw_held;
  logic                           r_w_held;
  logic [axil_addr_width_p-1:0]   r_awaddr;
  logic [axil_data_width_p-1:0]   r_wdata;
  logic                           r_wstrb_full;
  axi_resp_e                      r_bresp;

  logic                           w_aw_fire;
  logic                           w_w_fire;
  logic                           w_aw_have;
  logic                           w_w_have;
  logic [axil_addr_width_p-1:0]   w_addr_eff;
  logic                           w_strb_full_eff;
  logic                           w_wr_ok;
  logic                           w_wr_decide;

  assign w_aw_fire  = s_axil_awvalid_i && s_axil_awready_o;
  assign w_w_fire   = s_axil_wvalid_i && s_axil_wready_o;
  assign w_aw_have  = r_aw_held || w_aw_fire;
  assign w_w_have   = r_w_held || w_w_fire;

  // Decide on the cycle the second half arrives, so the stream beat starts one cycle later.
  assign w_addr_eff      = r_aw_held ? r_awaddr : s_axil_awaddr_i;
  assign w_strb_full_eff = r_w_held ? r_wstrb_full : (&s_axil_wstrb_i);
  assign w_wr_ok         = ((w_addr_eff == NBF_ADDR) || (w_addr_eff == MMIO_ADDR)) &&
                           w_strb_full_eff;
  assign w_wr_decide     = (r_wr_state == W_COLLECT) && w_aw_have && w_w_have;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_state <= W_COLLECT;
    end else begin
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      W_COLLECT: if (w_aw_have && w_w_have) w_wr_state_nxt = w_wr_ok ? W_STREAM : W_RESP;
      W_STREAM:  if (stream_yumi_i)         w_wr_state_nxt = W_RESP;
      W_RESP:    if (s_axil_bready_i)       w_wr_state_nxt = W_COLLECT;
      default:                              w_wr_state_nxt = W_COLLECT;
    endcase
  end

  always_comb begin
    s_axil_awready_o = 1'b0;
    s_axil_wready_o  = 1'b0;
    s_axil_bvalid_o  = 1'b0;
    stream_v_o       = 1'b0;
    case (r_wr_state)
      W_COLLECT: begin
        s_axil_awready_o = !r_aw_held && !reset_i;
        s_axil_wready_o  = !r_w_held && !reset_i;
      end
      W_STREAM: stream_v_o      = 1'b1;
      W_RESP:   s_axil_bvalid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_aw_held    <= 1'b0;
      r_w_held     <= 1'b0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb_full <= 1'b0;
      r_bresp      <= e_axi_resp_okay;
    end else begin
      if (w_aw_fire) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axil_awaddr_i;
      end
      if (w_w_fire) begin
        r_w_held     <= 1'b1;
        r_wdata      <= s_axil_wdata_i;
        r_wstrb_full <= &s_axil_wstrb_i;
      end
      if (w_wr_decide) begin
        r_bresp <= w_wr_ok ? e_axi_resp_okay : e_axi_resp_slverr;
      end
      if ((r_wr_state == W_RESP) && s_axil_bready_i) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  assign s_axil_bresp_o = r_bresp;
  assign stream_addr_o  = r_awaddr;
  assign stream_data_o  = r_wdata;

  // ---------------- return FIFO ----------------
  logic                           w_fifo_ready;
  logic                           w_fifo_v;
  logic [axil_data_width_p-1:0]   w_fifo_data;
  logic                           w_push;
  logic                           w_pop;
  logic [CNT_W-1:0]               r_rx_count;

  bp_stream_axil_bridge_fifo #(
    .width_p (axil_data_width_p),
    .els_p   (rx_fifo_els_p)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (stream_v_i),
    .ready_o (w_fifo_ready),
    .data_i  (stream_data_i),
    .v_o     (w_fifo_v),
    .data_o  (w_fifo_data),
    .yumi_i  (w_pop)
  );

  assign stream_ready_o = w_fifo_ready && !reset_i;
  assign w_push         = stream_v_i && stream_ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rx_count <= '0;
    end else if (w_push && !w_pop) begin
      r_rx_count <= r_rx_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      r_rx_count <= r_rx_count - CNT_W'(1);
    end
  end

  // ---------------- read path ----------------
  rd_state_e                      r_rd_state;
  rd_state_e                      w_rd_state_nxt;
  logic [axil_data_width_p-1:0]   r_rdata;
  axi_resp_e                      r_rresp;
  logic                           w_ar_fire;

  assign w_ar_fire = s_axil_arvalid_i && s_axil_arready_o;
  assign w_pop     = w_ar_fire && (s_axil_araddr_i == RXD_ADDR) && w_fifo_v;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rd_state <= R_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_ar_fire)       w_rd_state_nxt = R_RESP;
      R_RESP:  if (s_axil_rready_i) w_rd_state_nxt = R_IDLE;
      default:                      w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axil_arready_o = 1'b0;
    s_axil_rvalid_o  = 1'b0;
    case (r_rd_state)
      R_IDLE:  s_axil_arready_o = !reset_i;
      R_RESP:  s_axil_rvalid_o  = 1'b1;
      default: ;
    endcase
  end

  // Occupancy is the pre-update value, so a same-cycle push or pop is not reflected.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rdata <= '0;
      r_rresp <= e_axi_resp_okay;
    end else if (w_ar_fire) begin
      if (s_axil_araddr_i == RXD_ADDR) begin
        r_rdata <= w_fifo_v ? w_fifo_data : '0;
        r_rresp <= e_axi_resp_okay;
      end else if (s_axil_araddr_i == RXC_ADDR) begin
        r_rdata <= axil_data_width_p'(r_rx_count);
        r_rresp <= e_axi_resp_okay;
      end else begin
        r_rdata <= '0;
        r_rresp <= e_axi_resp_slverr;
      end
    end
  end

  assign s_axil_rdata_o = r_rdata;
  assign s_axil_rresp_o = r_rresp;

endmodule

// File: tb/tb_bp_stream_axil_bridge.sv
// Self-checking bench for bp_stream_axil_bridge: write vector table, FIFO corner sequences, random traffic.
module tb_bp_stream_axil_bridge;
  import bp_stream_axil_bridge_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] s_axil_awaddr_i;
  logic        s_axil_awvalid_i;
  logic        s_axil_awready_o;
  logic [31:0] s_axil_wdata_i;
  logic [3:0]  s_axil_wstrb_i;
  logic        s_axil_wvalid_i;
  logic        s_axil_wready_o;
  logic [1:0]  s_axil_bresp_o;
  logic        s_axil_bvalid_o;
  logic        s_axil_bready_i;
  logic [31:0] s_axil_araddr_i;
  logic        s_axil_arvalid_i;
  logic        s_axil_arready_o;
  logic [31:0] s_axil_rdata_o;
  logic [1:0]  s_axil_rresp_o;
  logic        s_axil_rvalid_o;
  logic        s_axil_rready_i;
  logic        stream_v_o;
  logic [31:0] stream_addr_o;
  logic [31:0] stream_data_o;
  logic        stream_yumi_i;
  logic        stream_v_i;
  logic [31:0] stream_data_i;
  logic        stream_ready_o;

  always #5 clk_i = ~clk_i;

  bp_stream_axil_bridge #(
    .axil_addr_width_p (32),
    .axil_data_width_p (32),
    .rx_fifo_els_p     (DEPTH)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .s_axil_awaddr_i  (s_axil_awaddr_i),
    .s_axil_awvalid_i (s_axil_awvalid_i),
    .s_axil_awready_o (s_axil_awready_o),
    .s_axil_wdata_i   (s_axil_wdata_i),
    .s_axil_wstrb_i   (s_axil_wstrb_i),
    .s_axil_wvalid_i  (s_axil_wvalid_i),
    .s_axil_wready_o  (s_axil_wready_o),
    .s_axil_bresp_o   (s_axil_bresp_o),
    .s_axil_bvalid_o  (s_axil_bvalid_o),
    .s_axil_bready_i  (s_axil_bready_i),
    .s_axil_araddr_i  (s_axil_araddr_i),
    .s_axil_arvalid_i (s_axil_arvalid_i),
    .s_axil_arready_o (s_axil_arready_o),
    .s_axil_rdata_o   (s_axil_rdata_o),
    .s_axil_rresp_o   (s_axil_rresp_o),
    .s_axil_rvalid_o  (s_axil_rvalid_o),
    .s_axil_rready_i  (s_axil_rready_i),
    .stream_v_o       (stream_v_o),
    .stream_addr_o    (stream_addr_o),
    .stream_data_o    (stream_data_o),
    .stream_yumi_i    (stream_yumi_i),
    .stream_v_i       (stream_v_i),
    .stream_data_i    (stream_data_i),
    .stream_ready_o   (stream_ready_o)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_start;
    int          w_start;
    int          yumi_wait;
    bit          exp_fwd;
    logic [1:0]  exp_resp;
  } wr_vec_t;

  int          checks = 0;
  int          errors = 0;
  int          beats  = 0;
  bit          rand_push = 1'b0;
  logic [31:0] model_q[$];
  logic [31:0] exp_rdata;
  logic [1:0]  exp_rresp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake did not complete within budget", name);
  endtask

  // One clock: called at a falling edge with inputs set, updates the reference model, ends at the next falling edge.
  task automatic tick();
    bit          push_f;
    bit          ar_f;
    logic [31:0] a;
    if (rand_push) begin
      stream_v_i    = 1'($urandom_range(0, 1));
      stream_data_i = $urandom;
    end
    check("rx_ready", 32'(stream_ready_o), 32'(model_q.size() < int'(DEPTH)));
    push_f = stream_v_i && stream_ready_o;
    ar_f   = s_axil_arvalid_i && s_axil_arready_o;
    if (stream_v_o && stream_yumi_i) beats++;
    if (ar_f) begin
      a = s_axil_araddr_i;
      if (a == 32'h30) begin
        exp_rresp = 2'b00;
        exp_rdata = (model_q.size() > 0) ? model_q.pop_front() : 32'h0;
      end else if (a == 32'h34) begin
        exp_rresp = 2'b00;
        exp_rdata = 32'(model_q.size());
      end else begin
        exp_rresp = 2'b10;
        exp_rdata = 32'h0;
      end
    end
    if (push_f) model_q.push_back(stream_data_i);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_write(input string nm, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_start, input int w_start,
                          input int yumi_wait, input bit exp_fwd, input logic [1:0] exp_resp);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_f;
    bit w_f;
    int cyc = 0;
    int b0;
    s_axil_awaddr_i = addr;
    s_axil_wdata_i  = data;
    s_axil_wstrb_i  = strb;
    while (!(aw_done && w_done)) begin
      if (cyc > 40) begin
        timeout_fail({nm, "_aw_w"});
        s_axil_awvalid_i = 1'b0;
        s_axil_wvalid_i  = 1'b0;
        return;
      end
      s_axil_awvalid_i = !aw_done && (cyc >= aw_start);
      s_axil_wvalid_i  = !w_done && (cyc >= w_start);
      aw_f = s_axil_awvalid_i && s_axil_awready_o;
      w_f  = s_axil_wvalid_i && s_axil_wready_o;
      tick();
      aw_done |= aw_f;
      w_done  |= w_f;
      cyc++;
    end
    s_axil_awvalid_i = 1'b0;
    s_axil_wvalid_i  = 1'b0;
    b0 = beats;
    if (exp_fwd) begin
      for (int k = 0; k <= yumi_wait; k++) begin
        check({nm, "_stream_v"}, 32'(stream_v_o), 32'd1);
        check({nm, "_stream_addr"}, stream_addr_o, addr);
        check({nm, "_stream_data"}, stream_data_o, data);
        if (k == yumi_wait) stream_yumi_i = 1'b1;
        tick();
      end
      stream_yumi_i = 1'b0;
    end
    check({nm, "_beats"}, 32'(beats - b0), exp_fwd ? 32'd1 : 32'd0);
    check({nm, "_stream_idle"}, 32'(stream_v_o), 32'd0);
    check({nm, "_bvalid"}, 32'(s_axil_bvalid_o), 32'd1);
    check({nm, "_bresp"}, 32'(s_axil_bresp_o), 32'(exp_resp));
    s_axil_bready_i = 1'b1;
    tick();
    s_axil_bready_i = 1'b0;
    check({nm, "_bvalid_drop"}, 32'(s_axil_bvalid_o), 32'd0);
    check({nm, "_awready_back"}, 32'(s_axil_awready_o), 32'd1);
  endtask

  task automatic do_read(input string nm, input logic [31:0] addr,
                         output logic [31:0] got, output logic [1:0] got_resp);
    int n = 0;
    got      = 32'hx;
    got_resp = 2'bx;
    s_axil_araddr_i  = addr;
    s_axil_arvalid_i = 1'b1;
    while (!s_axil_arready_o) begin
      if (n > 20) begin
        timeout_fail({nm, "_ar"});
        s_axil_arvalid_i = 1'b0;
        return;
      end
      n++;
      tick();
    end
    tick();
    s_axil_arvalid_i = 1'b0;
    check({nm, "_rvalid"}, 32'(s_axil_rvalid_o), 32'd1);
    check({nm, "_rdata"}, s_axil_rdata_o, exp_rdata);
    check({nm, "_rresp"}, 32'(s_axil_rresp_o), 32'(exp_rresp));
    got      = s_axil_rdata_o;
    got_resp = s_axil_rresp_o;
    s_axil_rready_i = 1'b1;
    tick();
    s_axil_rready_i = 1'b0;
    check({nm, "_rvalid_drop"}, 32'(s_axil_rvalid_o), 32'd0);
  endtask

  task automatic check_all_idle(input string nm);
    check({nm, "_stream_v"}, 32'(stream_v_o), 32'd0);
    check({nm, "_bvalid"}, 32'(s_axil_bvalid_o), 32'd0);
    check({nm, "_rvalid"}, 32'(s_axil_rvalid_o), 32'd0);
    check({nm, "_bresp"}, 32'(s_axil_bresp_o), 32'd0);
    check({nm, "_rresp"}, 32'(s_axil_rresp_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    wr_vec_t     wv[7];
    logic [31:0] got;
    logic [1:0]  got_resp;
    logic [31:0] addr_pool[4];
    logic [31:0] raddr_pool[4];

    wv[0] = '{"same_cycle",  32'h10, 32'hCAFE0001, 4'hF, 0, 0, 3, 1'b1, 2'b00};
    wv[1] = '{"w_first",     32'h20, 32'h00000005, 4'hF, 2, 0, 0, 1'b1, 2'b00};
    wv[2] = '{"bad_addr",    32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0, 2'b10};
    wv[3] = '{"part_strb",   32'h10, 32'h12345678, 4'h3, 0, 0, 0, 1'b0, 2'b10};
    wv[4] = '{"aw_first",    32'h20, 32'h0000A5A5, 4'hF, 0, 3, 1, 1'b1, 2'b00};
    wv[5] = '{"zero_strb",   32'h10, 32'h00000000, 4'h0, 1, 0, 0, 1'b0, 2'b10};
    wv[6] = '{"near_mmio",   32'h24, 32'h00000001, 4'hF, 0, 0, 2, 1'b0, 2'b10};
    addr_pool  = '{32'h10, 32'h20, 32'h40, 32'h14};
    raddr_pool = '{32'h30, 32'h30, 32'h34, 32'h50};

    reset_i          = 1'b1;
    s_axil_awaddr_i  = '0;
    s_axil_awvalid_i = 1'b0;
    s_axil_wdata_i   = '0;
    s_axil_wstrb_i   = '0;
    s_axil_wvalid_i  = 1'b0;
    s_axil_bready_i  = 1'b0;
    s_axil_araddr_i  = '0;
    s_axil_arvalid_i = 1'b0;
    s_axil_rready_i  = 1'b0;
    stream_yumi_i    = 1'b0;
    stream_v_i       = 1'b0;
    stream_data_i    = '0;
    exp_rdata        = '0;
    exp_rresp        = '0;

    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    check_all_idle("reset");
    check("reset_awready", 32'(s_axil_awready_o), 32'd0);
    check("reset_arready", 32'(s_axil_arready_o), 32'd0);
    check("reset_stream_ready", 32'(stream_ready_o), 32'd0);
    reset_i = 1'b0;
    #1;
    check("post_reset_awready", 32'(s_axil_awready_o), 32'd1);
    @(negedge clk_i);

    // Write vector table
    foreach (wv[i]) begin
      do_write(wv[i].name, wv[i].addr, wv[i].data, wv[i].strb, wv[i].aw_start,
               wv[i].w_start, wv[i].yumi_wait, wv[i].exp_fwd, wv[i].exp_resp);
    end

    // Fill FIFO to full, then over-drive
    stream_v_i = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      stream_data_i = 32'(i);
      tick();
    end
    check("full_ready_drop", 32'(stream_ready_o), 32'd0);
    stream_data_i = 32'hDEAD0000;
    tick();
    tick();
    stream_v_i = 1'b0;
    do_read("full_count", 32'h34, got, got_resp);
    check("full_count_val", got, 32'd16);
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_read("drain", 32'h30, got, got_resp);
      check("drain_order", got, 32'(i));
    end
    do_read("empty_pop", 32'h30, got, got_resp);
    check("empty_pop_data", got, 32'd0);
    check("empty_pop_resp", 32'(got_resp), 32'd0);

    // Pop and push in the same cycle on a one-entry FIFO
    stream_v_i    = 1'b1;
    stream_data_i = 32'hAA;
    tick();
    s_axil_araddr_i  = 32'h30;
    s_axil_arvalid_i = 1'b1;
    stream_data_i    = 32'hBB;
    tick();
    s_axil_arvalid_i = 1'b0;
    stream_v_i       = 1'b0;
    check("overlap_rvalid", 32'(s_axil_rvalid_o), 32'd1);
    check("overlap_rdata", s_axil_rdata_o, 32'hAA);
    check("overlap_rdata_model", s_axil_rdata_o, exp_rdata);
    s_axil_rready_i = 1'b1;
    tick();
    s_axil_rready_i = 1'b0;
    do_read("overlap_count", 32'h34, got, got_resp);
    check("overlap_count_val", got, 32'd1);
    do_read("bad_raddr", 32'h50, got, got_resp);
    check("bad_raddr_data", got, 32'd0);
    check("bad_raddr_resp", 32'(got_resp), 32'd2);
    do_read("overlap_tail", 32'h30, got, got_resp);
    check("overlap_tail_val", got, 32'hBB);

    // Random traffic against the reference model
    rand_push = 1'b1;
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 2))
        0: do_read("rnd_rd", raddr_pool[$urandom_range(0, 3)], got, got_resp);
        1: begin
          logic [31:0] a;
          logic [3:0]  s;
          a = addr_pool[$urandom_range(0, 3)];
          s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
          do_write("rnd_wr", a, $urandom, s, $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 3), (a == 32'h10 || a == 32'h20) && (s == 4'hF),
                   ((a == 32'h10 || a == 32'h20) && (s == 4'hF)) ? 2'b00 : 2'b10);
        end
        default: tick();
      endcase
    end
    rand_push  = 1'b0;
    stream_v_i = 1'b0;
    do_read("rnd_final_count", 32'h34, got, got_resp);

    // Reset in the middle of a stream beat with a read response pending
    stream_v_i    = 1'b1;
    stream_data_i = 32'h77;
    tick();
    stream_v_i       = 1'b0;
    s_axil_awaddr_i  = 32'h10;
    s_axil_wdata_i   = 32'h00001234;
    s_axil_wstrb_i   = 4'hF;
    s_axil_awvalid_i = 1'b1;
    s_axil_wvalid_i  = 1'b1;
    s_axil_araddr_i  = 32'h34;
    s_axil_arvalid_i = 1'b1;
    tick();
    s_axil_awvalid_i = 1'b0;
    s_axil_wvalid_i  = 1'b0;
    s_axil_arvalid_i = 1'b0;
    check("pre_rst_stream_v", 32'(stream_v_o), 32'd1);
    check("pre_rst_rvalid", 32'(s_axil_rvalid_o), 32'd1);
    reset_i = 1'b1;
    #1;
    check_all_idle("mid_rst");
    check("mid_rst_stream_ready", 32'(stream_ready_o), 32'd0);
    model_q.delete();
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check_all_idle("after_rst");
    do_read("after_rst_count", 32'h34, got, got_resp);
    check("after_rst_count_val", got, 32'd0);
    do_write("after_rst_wr", 32'h20, 32'h0BADF00D, 4'hF, 0, 1, 1, 1'b1, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
